// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: receiver FSM states, frame geometry and
// scan-code constants used by this receiver and the downstream translator.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    STOP
  } ps2_state_e;

  // Start + 8 data + parity + stop
  localparam int PS2_FRAME_BITS = 11;
  // Bits shifted in while in SHIFT: 8 data bits followed by parity
  localparam int PS2_PAYLOAD_BITS = PS2_FRAME_BITS - 2;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  // Odd parity over data plus parity bit: the XOR of all nine must be 1
  function automatic logic ps2_parity_ok(input logic [8:0] payload);
    return ^payload;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO. Pointers carry one extra wrap bit so that
// full and empty can be told apart without a separate occupancy counter.
// A push while full is accepted only when a pop frees a slot in the same
// cycle; a pop while empty is ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Head entry is presented as zero while empty so the output is defined.
  assign rdata = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // Next-pointer computation.
  always_comb begin
    // NOTE: every signal written here gets a default first, otherwise a
    // path that leaves it unassigned infers a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; the pointers alone
    // define which entries are valid, and an unreset array maps onto RAM.
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronises the raw pins, deserialises
// 11-bit frames, checks start/parity/stop and queues good scan codes for a
// ready / nextdata_n pull consumer. Errors and drops raise sticky flags.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 12000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic          clk_s1_q, clk_s2_q, clk_s3_q;
  logic          data_s1_q, data_s2_q;
  logic          fall, bit_in;

  ps2_state_e    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [8:0]    shift_q, shift_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          overflow_q, overflow_d;
  logic          frame_err_q, frame_err_d;

  logic          push, full, empty;

  // Two-flop synchronisers plus an edge-detect stage on the clock path;
  // reset to 1 because that is the idle bus level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1_q  <= 1'b1;
      clk_s2_q  <= 1'b1;
      clk_s3_q  <= 1'b1;
      data_s1_q <= 1'b1;
      data_s2_q <= 1'b1;
    end else begin
      clk_s1_q  <= ps2_clk;
      clk_s2_q  <= clk_s1_q;
      clk_s3_q  <= clk_s2_q;
      data_s1_q <= ps2_data;
      data_s2_q <= data_s1_q;
    end
  end

  assign fall   = clk_s3_q & ~clk_s2_q;
  assign bit_in = data_s2_q;

  // Frame deserialiser, inactivity timeout and sticky error flags.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    tmo_d       = tmo_q;
    overflow_d  = overflow_q;
    frame_err_d = frame_err_q;
    push        = 1'b0;

    unique case (state_q)
      IDLE: begin
        tmo_d = '0;
        // A high bit here is a line glitch, not a start bit: ignore it.
        if (fall && !bit_in) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end
      SHIFT, STOP: begin
        if (fall) begin
          tmo_d = '0;
          if (state_q == SHIFT) begin
            // LSB arrives first; after nine shifts shift_q = {parity, data}.
            shift_d = {bit_in, shift_q[8:1]};
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'(PS2_PAYLOAD_BITS - 1)) state_d = STOP;
          end else begin
            if (bit_in && ps2_parity_ok(shift_q)) push = 1'b1;
            else                                  frame_err_d = 1'b1;
            state_d = IDLE;
          end
        end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
          // Device went quiet mid-frame: abandon the partial byte.
          tmo_d       = '0;
          state_d     = IDLE;
          frame_err_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Full implies non-empty, so a high nextdata_n means no slot is freed.
    if (push && full && nextdata_n) overflow_d = 1'b1;
  end

  // Deserialiser state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      tmo_q       <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      tmo_q       <= tmo_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (~nextdata_n),
    .wdata (shift_q[7:0]),
    .rdata (data),
    .full  (full),
    .empty (empty)
  );

  assign ready     = ~empty;
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: a table of single-frame vectors, hand-written
// sequences for latency, overflow, same-cycle push/pop, timeout and
// mid-frame reset, then random frames against a queue-based model.
module tb_ps2_rx_fifo;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       nextdata_n = 1'b1;
  logic [7:0] data;
  logic       ready, overflow, frame_err;

  int checks = 0;
  int failures = 0;

  // Reference model: byte queue plus sticky flags
  logic [7:0] model_q[$];
  logic       model_ovf;
  logic       model_ferr;

  typedef struct {
    logic [7:0] b;
    logic       bad_par;
    logic       bad_stop;
    logic       exp_ready;
    logic [7:0] exp_data;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[8];

  ps2_rx_fifo #(
    .FIFO_DEPTH  (DEPTH),
    .TIMEOUT_CYC (100)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .nextdata_n (nextdata_n),
    .data       (data),
    .ready      (ready),
    .overflow   (overflow),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    nextdata_n = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    model_q.delete();
    model_ovf = 1'b0;
    model_ferr = 1'b0;
  endtask

  // One PS/2 bit: data set while the clock is high, then a clock low phase
  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (10) tick();
    ps2_clk = 1'b0;
    repeat (10) tick();
    ps2_clk = 1'b1;
  endtask

  // Start, 8 data bits LSB first, and the odd-parity bit (optionally wrong)
  task automatic frame_head(input logic [7:0] b, input logic bad_par);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ bad_par);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    frame_head(b, bad_par);
    ps2_bit(~bad_stop);
    tick();
  endtask

  task automatic pop_pulse();
    nextdata_n = 1'b0;
    tick();
    nextdata_n = 1'b1;
  endtask

  task automatic model_frame(input logic [7:0] b, input logic bad);
    if (bad) model_ferr = 1'b1;
    else if (model_q.size() < DEPTH) model_q.push_back(b);
    else model_ovf = 1'b1;
  endtask

  task automatic model_check(input string tag);
    check({tag, "_ready"}, ready, model_q.size() > 0);
    if (model_q.size() > 0) check({tag, "_data"}, data, model_q[0]);
    check({tag, "_ovf"}, overflow, model_ovf);
    check({tag, "_ferr"}, frame_err, model_ferr);
  endtask

  initial begin
    int n;
    vecs[0] = '{8'h1C, 1'b0, 1'b0, 1'b1, 8'h1C, 1'b0};
    vecs[1] = '{8'hF0, 1'b0, 1'b0, 1'b1, 8'hF0, 1'b0};
    vecs[2] = '{8'hE0, 1'b0, 1'b0, 1'b1, 8'hE0, 1'b0};
    vecs[3] = '{8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0};
    vecs[4] = '{8'hFF, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0};
    vecs[5] = '{8'h1C, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1};
    vecs[6] = '{8'h32, 1'b0, 1'b0, 1'b1, 8'h32, 1'b1};
    vecs[7] = '{8'h55, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1};

    // Reset state
    do_reset();
    check("rst_ready", ready, 1'b0);
    check("rst_data", data, 8'h00);
    check("rst_ovf", overflow, 1'b0);
    check("rst_ferr", frame_err, 1'b0);

    // Single 1C frame: latency from the stop-bit pin edge to ready
    frame_head(8'h1C, 1'b0);
    ps2_data = 1'b1;
    repeat (10) tick();
    ps2_clk = 1'b0;
    tick();
    check("lat_early", ready, 1'b0);
    n = 0;
    while (!ready && n < 6) begin
      tick();
      n++;
    end
    check("lat_cycles", n, 2);
    check("lat_ready", ready, 1'b1);
    check("lat_data", data, 8'h1C);
    check("lat_ferr", frame_err, 1'b0);
    repeat (10) tick();
    ps2_clk = 1'b1;
    tick();

    // Glitch in IDLE, then F0, 1C and single-cycle pops
    do_reset();
    ps2_bit(1'b1);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    check("seq_ferr", frame_err, 1'b0);
    check("seq_ready0", ready, 1'b1);
    check("seq_data0", data, 8'hF0);
    pop_pulse();
    check("seq_ready1", ready, 1'b1);
    check("seq_data1", data, 8'h1C);
    pop_pulse();
    check("seq_ready2", ready, 1'b0);

    // Table of single frames, each popped before the next
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send_frame(vecs[i].b, vecs[i].bad_par, vecs[i].bad_stop);
      check($sformatf("vec%0d_ready", i), ready, vecs[i].exp_ready);
      if (vecs[i].exp_ready) check($sformatf("vec%0d_data", i), data, vecs[i].exp_data);
      check($sformatf("vec%0d_ferr", i), frame_err, vecs[i].exp_ferr);
      check($sformatf("vec%0d_ovf", i), overflow, 1'b0);
      pop_pulse();
      check($sformatf("vec%0d_empty", i), ready, 1'b0);
    end

    // Nine frames without pops: the ninth is dropped
    do_reset();
    for (int i = 0; i < DEPTH; i++) send_frame(8'h10 + 8'(i), 1'b0, 1'b0);
    check("ovf_before", overflow, 1'b0);
    send_frame(8'hAA, 1'b0, 1'b0);
    check("ovf_after", overflow, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("ovf_drain%0d", i), data, 8'h10 + 8'(i));
      pop_pulse();
    end
    check("ovf_empty", ready, 1'b0);
    check("ovf_sticky", overflow, 1'b1);

    // Full FIFO, push and pop on the same edge
    do_reset();
    for (int i = 0; i < DEPTH; i++) send_frame(8'h20 + 8'(i), 1'b0, 1'b0);
    frame_head(8'h77, 1'b0);
    ps2_data = 1'b1;
    repeat (10) tick();
    ps2_clk = 1'b0;
    tick();
    tick();
    nextdata_n = 1'b0;
    tick();
    nextdata_n = 1'b1;
    repeat (8) tick();
    ps2_clk = 1'b1;
    tick();
    check("coll_ovf", overflow, 1'b0);
    for (int i = 1; i < DEPTH; i++) begin
      check($sformatf("coll_drain%0d", i), data, 8'h20 + 8'(i));
      pop_pulse();
    end
    check("coll_last", data, 8'h77);
    check("coll_last_ready", ready, 1'b1);
    pop_pulse();
    check("coll_empty", ready, 1'b0);

    // Partial frame abandoned by the timeout, then a normal frame
    do_reset();
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    check("tmo_pre_ferr", frame_err, 1'b0);
    repeat (150) tick();
    check("tmo_ferr", frame_err, 1'b1);
    check("tmo_ready", ready, 1'b0);
    send_frame(8'h45, 1'b0, 1'b0);
    check("tmo_next_ready", ready, 1'b1);
    check("tmo_next_data", data, 8'h45);

    // Asynchronous reset in the middle of a frame (FIFO holds 45, ferr set)
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_data = 1'b0;
    repeat (5) tick();
    ps2_clk = 1'b0;
    #3 rst = 1'b1;
    #1;
    check("mrst_ready", ready, 1'b0);
    check("mrst_data", data, 8'h00);
    check("mrst_ovf", overflow, 1'b0);
    check("mrst_ferr", frame_err, 1'b0);
    #5 ps2_clk = 1'b1;
    ps2_data = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    send_frame(8'h1C, 1'b0, 1'b0);
    check("mrst_next_ready", ready, 1'b1);
    check("mrst_next_data", data, 8'h1C);
    check("mrst_next_ferr", frame_err, 1'b0);

    // Random frames, errors and pops against the queue model
    do_reset();
    for (int i = 0; i < 40; i++) begin
      logic [7:0] b;
      logic bad_par, bad_stop;
      int npop;
      b = 8'($urandom);
      bad_par = 1'b0;
      bad_stop = 1'b0;
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 1) == 0) bad_par = 1'b1;
        else bad_stop = 1'b1;
      end
      send_frame(b, bad_par, bad_stop);
      model_frame(b, bad_par | bad_stop);
      model_check($sformatf("rnd%0d", i));
      npop = $urandom_range(0, 2);
      for (int k = 0; k < npop; k++) begin
        pop_pulse();
        if (model_q.size() > 0) void'(model_q.pop_front());
        model_check($sformatf("rnd%0d_pop%0d", i, k));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
PS/2 device-to-host receiver that sits directly upstream of the scan-code/ASCII translation stage. It synchronises the raw ps2_clk/ps2_data pins and deserialises 11-bit frames. It checks start, parity and stop, then buffers good scan codes in a small FIFO. It presents them through the ready / nextdata_n pull handshake that the downstream keyboard logic consumes.

Parameters:
FIFO_DEPTH, 8, number of buffered scan codes; power of two, at least 2
TIMEOUT_CYC, 12000, clk cycles without a ps2_clk falling edge after which a partial frame is abandoned

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
ps2_clk  in  1  raw PS/2 clock pin, asynchronous
ps2_data  in  1  raw PS/2 data pin, asynchronous
nextdata_n  in  1  active-low pop request from consumer
data  out  8  scan code at FIFO head; valid only while ready=1
ready  out  1  FIFO non-empty
overflow  out  1  sticky: at least one good byte was dropped because the FIFO was full
frame_err  out  1  sticky: at least one frame failed the start, parity or stop check

Behaviour:
- Reset: async assert. FIFO empty, ready=0, data=8'h00, overflow=0, frame_err=0, FSM=IDLE, bit counter=0, timeout counter=0. Synchroniser flops reset to 1 (bus idle level).
- Sync: each of ps2_clk and ps2_data passes through 2 flops. A third flop on the clock path gives fall = prev & ~cur. Fall is one clk cycle wide, 3 cycles after the pin edge.
- All sampling uses synced ps2_data on cycles where fall=1.
- FSM states:
  - IDLE: on fall with data=0, go to SHIFT and set cnt=0. On fall with data=1 (glitch), stay in IDLE with no error.
  - SHIFT: on each fall, store the bit at position cnt (LSB first: 8 data bits, then parity at cnt=8) and increment cnt. After the parity bit, go to STOP.
  - STOP: on fall, check stop==1 and odd parity (XOR of 8 data bits and parity bit == 1). Pass: push byte. Fail: set frame_err and drop the byte. Either way, return to IDLE.
- Timeout: in SHIFT or STOP, the counter increments every cycle and clears on fall. On reaching TIMEOUT_CYC, return to IDLE, set frame_err and discard the partial frame. The counter is held at 0 in IDLE.
- Push latency: the byte is written on the clk edge where the stop-bit fall is seen. ready=1 and data=byte from the next cycle.
- Pop: occurs on each rising clk edge where ready=1 and nextdata_n=0.
  - Holding nextdata_n low for several cycles pops one byte per cycle.
  - Pop while empty is ignored.
  - data shows the new head on the cycle after a pop.
- FIFO: circular buffer with read/write pointers that are one bit wider than the address. full when the MSBs differ and the lower bits are equal; empty when all bits are equal. Pointers wrap modulo 2*FIFO_DEPTH.
- Push to full FIFO, no pop in the same cycle: byte dropped, overflow=1, contents unchanged.
- Push and pop in the same cycle while full: both happen, count unchanged, no overflow.
- Push and pop in the same cycle while empty: pop ignored, push accepted.
- overflow and frame_err clear only on rst.
- rst mid-frame: the frame is lost and the FSM restarts in IDLE. The next start bit is received normally.

Decomposition:
- Shared package ps2_pkg:
  - FSM state enum (IDLE, SHIFT, STOP)
  - PS2_FRAME_BITS=11
  - common scan-code constants such as PS2_BREAK=8'hF0 and PS2_EXT=8'hE0, also used downstream
- One natural sub-module: sync_fifo (parameterised WIDTH, DEPTH; push, pop, full, empty, rdata). It is reusable by other stages.
- The synchroniser and deserialiser FSM stay in ps2_rx_fifo.

Test Plan:
- Single frame for 8'h1C (parity 0), nextdata_n held high: ready=1 and data=8'h1C 1 cycle after the stop-bit fall is detected; frame_err=0.
- Frames 8'hF0, 8'h1C, then a 1-cycle nextdata_n=0 pulse: data shows F0, then 1C after the pop; ready stays 1 until the second pop, then 0.
- Frame 8'h1C with wrong parity bit (1): no push, ready stays 0, frame_err=1. A following good 8'h32 frame is received normally.
- FIFO_DEPTH+1 = 9 good frames with no pops: overflow=1 after the 9th. Popping drains exactly 8 bytes in send order, then ready=0.
- With the FIFO full, deliver a frame and pulse nextdata_n=0 on the same cycle as the push: overflow stays 0 and the count stays 8.
- With TIMEOUT_CYC=100, send start plus 4 bits, then idle for 150 cycles: FSM back in IDLE, frame_err=1. Then send a full 8'h45 frame: data=8'h45 is received. Separately, assert rst mid-frame: all outputs go to their reset values immediately.
